// File: rtl/instr_fetch_queue.sv
// Prefetch FIFO of {PC, instruction, adel} between fetch and decode, flushed on redirect.
// Optional same-cycle pass-through on an empty queue when IFQ_BYPASS_EN is defined.
module instr_fetch_queue #(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_pc,
   input  logic [31:0]      in_instr,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_pc,
   output logic [31:0]      out_instr,
   output logic             out_adel,
   output logic [PTR_W:0]   count
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [31:0]      r_pc_mem    [DEPTH];
   logic [31:0]      r_instr_mem [DEPTH];
   logic             r_adel_mem  [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   logic             w_in_adel;
   logic [31:0]      w_in_instr;
   logic             w_empty;
   logic             w_full;
   logic             w_head_valid;
   logic             w_bypass;
   logic             w_push;
   logic             w_pop;

   // Misaligned fetches become nop-carrying address-error entries.
   assign w_in_adel    = (in_pc[1:0] != 2'b00);
   assign w_in_instr   = w_in_adel ? 32'h0000_0000 : in_instr;

   assign w_empty      = (r_count == '0);
   assign w_full       = (r_count == FULL_CNT);
   assign in_ready     = !w_full && !flush;
   assign w_head_valid = !w_empty && !flush;

`ifdef IFQ_BYPASS_EN
   assign w_bypass     = w_empty && in_valid && !flush;
   assign w_push       = in_valid && in_ready && !(w_bypass && out_ready);
`else
   assign w_bypass     = 1'b0;
   assign w_push       = in_valid && in_ready;
`endif

   assign out_valid    = w_head_valid || w_bypass;
   assign w_pop        = w_head_valid && out_ready;
   assign count        = r_count;

   always_comb begin
      out_pc    = 32'h0000_0000;
      out_instr = 32'h0000_0000;
      out_adel  = 1'b0;
      if (w_head_valid) begin
         out_pc    = r_pc_mem[r_rd_ptr];
         out_instr = r_instr_mem[r_rd_ptr];
         out_adel  = r_adel_mem[r_rd_ptr];
      end else if (w_bypass) begin
         out_pc    = in_pc;
         out_instr = w_in_instr;
         out_adel  = w_in_adel;
      end
   end

   // Storage is not reset; occupancy alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]    <= in_pc;
         r_instr_mem[r_wr_ptr] <= w_in_instr;
         r_adel_mem[r_wr_ptr]  <= w_in_adel;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue (default build): vector table plus
// hand-written streaming and asynchronous-reset sequences.
module tb_instr_fetch_queue;

   localparam int DEPTH = 4;
   localparam int PTR_W = $clog2(DEPTH);

   logic           clk = 1'b0;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   logic [31:0]    in_pc;
   logic [31:0]    in_instr;
   logic           flush;
   logic           out_valid;
   logic           out_ready;
   logic [31:0]    out_pc;
   logic [31:0]    out_instr;
   logic           out_adel;
   logic [PTR_W:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   instr_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .out_adel  (out_adel),
      .count     (count)
   );

   typedef struct packed {
      logic           iv;
      logic [31:0]    pc;
      logic [31:0]    instr;
      logic           fl;
      logic           ordy;
      logic           e_ir;
      logic           e_ov;
      logic [31:0]    e_pc;
      logic [31:0]    e_instr;
      logic           e_adel;
      logic [PTR_W:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                               input logic fl, input logic ordy, input logic e_ir, input logic e_ov,
                               input logic [31:0] e_pc, input logic [31:0] e_instr,
                               input logic e_adel, input int e_cnt);
      vec_t v;
      v.iv = iv; v.pc = pc; v.instr = instr; v.fl = fl; v.ordy = ordy;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_pc = e_pc; v.e_instr = e_instr;
      v.e_adel = e_adel; v.e_cnt = (PTR_W+1)'(e_cnt);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic e_ov, input logic [31:0] e_pc,
                            input logic [31:0] e_instr, input logic e_adel, input int e_cnt);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
      chk({tag, ".out_pc"},    out_pc,         e_pc);
      chk({tag, ".out_instr"}, out_instr,      e_instr);
      chk({tag, ".out_adel"},  32'(out_adel),  32'(e_adel));
      chk({tag, ".count"},     32'(count),     32'(e_cnt));
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later.
   task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                        input logic fl, input logic ordy);
      @(negedge clk);
      in_valid  = iv;
      in_pc     = pc;
      in_instr  = instr;
      flush     = fl;
      out_ready = ordy;
      #1;
   endtask

   initial begin
      // fill / full refusal / drain
      vecs.push_back(mk(0, 32'h0,    32'h0,        0, 0, 1, 0, 32'h0,    32'h0,        0, 0));
      vecs.push_back(mk(1, 32'h3000, 32'h20010001, 0, 0, 1, 0, 32'h0,    32'h0,        0, 0));
      vecs.push_back(mk(1, 32'h3004, 32'h20020002, 0, 0, 1, 1, 32'h3000, 32'h20010001, 0, 1));
      vecs.push_back(mk(1, 32'h3008, 32'h20030003, 0, 0, 1, 1, 32'h3000, 32'h20010001, 0, 2));
      vecs.push_back(mk(1, 32'h300C, 32'h20040004, 0, 0, 1, 1, 32'h3000, 32'h20010001, 0, 3));
      vecs.push_back(mk(1, 32'h3010, 32'h20050005, 0, 0, 0, 1, 32'h3000, 32'h20010001, 0, 4));
      vecs.push_back(mk(0, 32'h0,    32'h0,        0, 0, 0, 1, 32'h3000, 32'h20010001, 0, 4));
      vecs.push_back(mk(1, 32'h3010, 32'h20050005, 0, 1, 0, 1, 32'h3000, 32'h20010001, 0, 4));
      vecs.push_back(mk(0, 32'h0,    32'h0,        0, 1, 1, 1, 32'h3004, 32'h20020002, 0, 3));
      vecs.push_back(mk(0, 32'h0,    32'h0,        0, 1, 1, 1, 32'h3008, 32'h20030003, 0, 2));
      vecs.push_back(mk(0, 32'h0,    32'h0,        0, 1, 1, 1, 32'h300C, 32'h20040004, 0, 1));
      vecs.push_back(mk(0, 32'h0,    32'h0,        0, 1, 1, 0, 32'h0,    32'h0,        0, 0));
      // flush with 3 entries held and a simultaneous push of 0x4000
      vecs.push_back(mk(1, 32'h5000, 32'h11111111, 0, 0, 1, 0, 32'h0,    32'h0,        0, 0));
      vecs.push_back(mk(1, 32'h5004, 32'h22222222, 0, 0, 1, 1, 32'h5000, 32'h11111111, 0, 1));
      vecs.push_back(mk(1, 32'h5008, 32'h33333333, 0, 0, 1, 1, 32'h5000, 32'h11111111, 0, 2));
      vecs.push_back(mk(1, 32'h4000, 32'h44444444, 1, 1, 0, 0, 32'h0,    32'h0,        0, 3));
      vecs.push_back(mk(0, 32'h0,    32'h0,        0, 1, 1, 0, 32'h0,    32'h0,        0, 0));
      vecs.push_back(mk(0, 32'h0,    32'h0,        0, 1, 1, 0, 32'h0,    32'h0,        0, 0));
      // misaligned entries, then an aligned one behind it
      vecs.push_back(mk(1, 32'h3006, 32'h8C010000, 0, 0, 1, 0, 32'h0,    32'h0,        0, 0));
      vecs.push_back(mk(1, 32'h3008, 32'h8C020004, 0, 1, 1, 1, 32'h3006, 32'h0,        1, 1));
      vecs.push_back(mk(0, 32'h0,    32'h0,        0, 1, 1, 1, 32'h3008, 32'h8C020004, 0, 1));
      vecs.push_back(mk(1, 32'h3001, 32'hFFFFFFFF, 0, 0, 1, 0, 32'h0,    32'h0,        0, 0));
      vecs.push_back(mk(0, 32'h0,    32'h0,        0, 0, 1, 1, 32'h3001, 32'h0,        1, 1));
      vecs.push_back(mk(0, 32'h0,    32'h0,        0, 1, 1, 1, 32'h3001, 32'h0,        1, 1));
      vecs.push_back(mk(0, 32'h0,    32'h0,        0, 0, 1, 0, 32'h0,    32'h0,        0, 0));

      // reset state, checked before any clock edge
      reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
      #3;
      check_out("reset", 0, 32'h0, 32'h0, 0, 0);
      @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].iv, vecs[i].pc, vecs[i].instr, vecs[i].fl, vecs[i].ordy);
         chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
         check_out($sformatf("v%0d", i), vecs[i].e_ov, vecs[i].e_pc, vecs[i].e_instr,
                   vecs[i].e_adel, int'(vecs[i].e_cnt));
      end

      // streaming: one push and one pop per cycle, wrapping pointers several times
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 32'h3000 + 32'(4 * i), 32'h1000_0000 + 32'(i), 1'b0, 1'b1);
         chk($sformatf("s%0d.in_ready", i), 32'(in_ready), 32'h1);
         if (i == 0)
            check_out($sformatf("s%0d", i), 0, 32'h0, 32'h0, 0, 0);
         else
            check_out($sformatf("s%0d", i), 1, 32'h3000 + 32'(4 * (i - 1)),
                      32'h1000_0000 + 32'(i - 1), 0, 1);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      check_out("s_tail", 1, 32'h3000 + 32'(4 * 19), 32'h1000_0000 + 32'd19, 0, 1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      check_out("s_empty", 0, 32'h0, 32'h0, 0, 0);

      // asynchronous reset with two entries held
      drive(1'b1, 32'h7000, 32'h77770000, 1'b0, 1'b0);
      drive(1'b1, 32'h7004, 32'h77770004, 1'b0, 1'b0);
      check_out("ar_fill", 1, 32'h7000, 32'h77770000, 0, 1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check_out("ar_pre", 1, 32'h7000, 32'h77770000, 0, 2);
      #2;
      reset = 1'b0;
      #1;
      check_out("ar_now", 0, 32'h0, 32'h0, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      chk("ar_post.in_ready", 32'(in_ready), 32'h1);
      check_out("ar_post", 0, 32'h0, 32'h0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
